// File: rtl/riscv_mem_arbiter.sv
// Two-port to single-port arbiter sharing one unified memory between fetch (IF) and data (DM).
// Data accesses win arbitration; a saturating starvation counter bounds how long a fetch can wait.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef DMEM_ADDR_WIDTH
`define DMEM_ADDR_WIDTH 32
`endif
`ifndef MEM_WIDTH
`define MEM_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module riscv_mem_arbiter #(
  parameter int PC_WIDTH        = `PC_WIDTH,
  parameter int DMEM_ADDR_WIDTH = `DMEM_ADDR_WIDTH,
  parameter int MEM_WIDTH       = `MEM_WIDTH,
  parameter int INST_WIDTH      = `INST_WIDTH,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       if_req,
  input  logic [PC_WIDTH-1:0]        if_addr,
  output logic                       if_gnt,
  output logic                       if_rvalid,
  output logic [INST_WIDTH-1:0]      if_rdata,
  input  logic                       dm_req,
  input  logic                       dm_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] dm_addr,
  input  logic [MEM_WIDTH-1:0]       dm_wdata,
  input  logic [MEM_WIDTH/8-1:0]     dm_wstrb,
  output logic                       dm_gnt,
  output logic                       dm_rvalid,
  output logic [MEM_WIDTH-1:0]       dm_rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]       mem_wdata,
  output logic [MEM_WIDTH/8-1:0]     mem_wstrb,
  input  logic                       mem_ready,
  input  logic [MEM_WIDTH-1:0]       mem_rdata
);

  localparam int         STRB_WIDTH = MEM_WIDTH / 8;
  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] BUSY_IF    = 2'd1;
  localparam logic [1:0] BUSY_DM    = 2'd2;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0]                 state;
  logic [3:0]                 starve_cnt;
  logic [DMEM_ADDR_WIDTH-1:0] if_addr_ext;

  // Fetch addresses are narrower than memory addresses; pad the upper bits with zeros
  always_comb begin
    if_addr_ext                 = {DMEM_ADDR_WIDTH{1'b0}};
    if_addr_ext[PC_WIDTH-1:0]   = if_addr;
  end

  // Grant decision: only in IDLE, DM first unless IF has sat through STARVE_LIMIT DM grants
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (reset_n && (state == IDLE)) begin
      if (dm_req && !(if_req && (starve_cnt == STARVE_MAX))) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
      end
    end else begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
    end
  end

  // Transaction FSM: latch the winner, hold fields while busy, return data on mem_ready
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= {DMEM_ADDR_WIDTH{1'b0}};
      mem_wdata  <= {MEM_WIDTH{1'b0}};
      mem_wstrb  <= {STRB_WIDTH{1'b0}};
      if_rvalid  <= 1'b0;
      if_rdata   <= {INST_WIDTH{1'b0}};
      dm_rvalid  <= 1'b0;
      dm_rdata   <= {MEM_WIDTH{1'b0}};
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_gnt) begin
            state     <= BUSY_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wstrb <= dm_wstrb;
            // Count DM grants that a waiting fetch has had to sit through
            if (if_req) begin
              if (starve_cnt < STARVE_MAX) begin
                starve_cnt <= starve_cnt + 4'd1;
              end else begin
                starve_cnt <= starve_cnt;
              end
            end else begin
              starve_cnt <= 4'd0;
            end
          end else if (if_gnt) begin
            state      <= BUSY_IF;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr_ext;
            mem_wdata  <= {MEM_WIDTH{1'b0}};
            mem_wstrb  <= {STRB_WIDTH{1'b0}};
            starve_cnt <= 4'd0;
          end else begin
            state <= IDLE;
          end
        end
        BUSY_IF: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            if_rdata  <= INST_WIDTH'(mem_rdata);
            if_rvalid <= 1'b1;
          end else begin
            state <= BUSY_IF;
          end
        end
        BUSY_DM: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            dm_rdata  <= mem_rdata;
            dm_rvalid <= 1'b1;
          end else begin
            state <= BUSY_DM;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: requesters push expected responses at grant time,
// a monitor pops and compares on rvalid, and a memory responder checks the latched fields.
module tb_riscv_mem_arbiter;

  localparam int PW    = 12;
  localparam int AW    = 16;
  localparam int MW    = 32;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        is_if;
  } txn_t;

  typedef struct packed {
    logic        is_wr;
    logic [31:0] data;
  } dexp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req;
  logic [PW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [MW-1:0] if_rdata;
  logic          dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [MW-1:0] dm_wdata;
  logic [3:0]    dm_wstrb;
  logic          dm_gnt, dm_rvalid;
  logic [MW-1:0] dm_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic [MW-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem  [logic [13:0]];
  logic [31:0] phys_mem [logic [13:0]];
  logic [31:0] exp_if_q [$];
  dexp_t       exp_dm_q [$];
  txn_t        txn_q    [$];

  int  fixed_lat   = 0;
  bit  spurious_en = 1'b0;
  int  reset_seen  = 0;
  int  dm_gnt_total = 0;
  int  dm_at_if_gnt = 0;
  int  dm_rv_total  = 0;
  time t_if_gnt, t_dm_gnt, t_dm_rv;

  riscv_mem_arbiter #(
    .PC_WIDTH(PW), .DMEM_ADDR_WIDTH(AW), .MEM_WIDTH(MW), .INST_WIDTH(MW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [13:0] ix);
    return (32'(ix) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [13:0] ix);
    return ref_mem.exists(ix) ? ref_mem[ix] : init_word(ix);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [13:0] ix);
    return phys_mem.exists(ix) ? phys_mem[ix] : init_word(ix);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // Memory model: random or fixed wait states, checks latched fields every busy cycle
  initial begin
    txn_t        cur;
    bit          cur_valid = 1'b0;
    int          wait_left = 0;
    int          seen = 0;
    logic [13:0] ix;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (seen != reset_seen) begin
        seen = reset_seen;
        cur_valid = 1'b0;
        txn_q.delete();
      end
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (mem_req === 1'b1) begin
        if (!cur_valid) begin
          total++;
          if (txn_q.size() == 0) begin
            bad++;
            $display("FAIL mem_unexpected: mem_req=1 addr=%h, required no transaction", mem_addr);
          end else begin
            cur = txn_q.pop_front();
            cur_valid = 1'b1;
            wait_left = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
          end
        end
        if (cur_valid) begin
          total++;
          if (mem_we !== cur.we || mem_addr !== cur.addr || mem_wstrb !== cur.wstrb ||
              (!cur.is_if && mem_wdata !== cur.wdata)) begin
            bad++;
            $display("FAIL mem_fields: got we=%0b addr=%h wdata=%h wstrb=%h, required we=%0b addr=%h wdata=%h wstrb=%h",
                     mem_we, mem_addr, mem_wdata, mem_wstrb, cur.we, cur.addr, cur.wdata, cur.wstrb);
          end
          if (wait_left == 0) begin
            mem_ready = 1'b1;
            ix = cur.addr[15:2];
            if (cur.we) phys_mem[ix] = merge(phys_rd(ix), cur.wdata, cur.wstrb);
            else        mem_rdata = phys_rd(ix);
            cur_valid = 1'b0;
          end else begin
            wait_left--;
          end
        end
      end else begin
        mem_ready = spurious_en && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Response scoreboard and arbitration model, sampled on the falling edge
  initial begin
    bit          outstanding = 1'b0;
    int          waits = 0;
    logic [31:0] last_if = 32'h0;
    logic [31:0] last_dm = 32'h0;
    bit          dm_known = 1'b1;
    logic [31:0] e;
    dexp_t       de;
    bit          exp_i, exp_d;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        outstanding = 1'b0;
        waits = 0;
        last_if = 32'h0;
        last_dm = 32'h0;
        dm_known = 1'b1;
        exp_if_q.delete();
        exp_dm_q.delete();
        reset_seen++;
      end else begin
        total++;
        if (if_rvalid) begin
          outstanding = 1'b0;
          if (exp_if_q.size() == 0) begin
            bad++;
            $display("FAIL if_rvalid_unexpected: got rvalid rdata=%h, required none", if_rdata);
          end else begin
            e = exp_if_q.pop_front();
            last_if = e;
            if (if_rdata !== e) begin
              bad++;
              $display("FAIL if_rdata: got %h, required %h", if_rdata, e);
            end
          end
        end else if (if_rdata !== last_if) begin
          bad++;
          $display("FAIL if_rdata_hold: got %h, required %h", if_rdata, last_if);
        end
        total++;
        if (dm_rvalid) begin
          outstanding = 1'b0;
          dm_rv_total++;
          t_dm_rv = $time;
          if (exp_dm_q.size() == 0) begin
            bad++;
            $display("FAIL dm_rvalid_unexpected: got rvalid rdata=%h, required none", dm_rdata);
          end else begin
            de = exp_dm_q.pop_front();
            dm_known = !de.is_wr;
            last_dm = de.data;
            if (!de.is_wr && dm_rdata !== de.data) begin
              bad++;
              $display("FAIL dm_rdata: got %h, required %h", dm_rdata, de.data);
            end
          end
        end else if (dm_known && dm_rdata !== last_dm) begin
          bad++;
          $display("FAIL dm_rdata_hold: got %h, required %h", dm_rdata, last_dm);
        end
        total++;
        if (if_rvalid && dm_rvalid) begin
          bad++;
          $display("FAIL rvalid_both: got if_rvalid=1 dm_rvalid=1, required at most one");
        end
        exp_i = 1'b0;
        exp_d = 1'b0;
        if (!outstanding && (if_req || dm_req)) begin
          if (dm_req && !(if_req && waits == LIMIT)) exp_d = 1'b1;
          else exp_i = 1'b1;
        end
        if (if_req || dm_req || if_gnt || dm_gnt) begin
          total++;
          if ({if_gnt, dm_gnt} !== {exp_i, exp_d}) begin
            bad++;
            $display("FAIL grant: got if_gnt=%0b dm_gnt=%0b, required if_gnt=%0b dm_gnt=%0b (waits=%0d)",
                     if_gnt, dm_gnt, exp_i, exp_d, waits);
          end
        end
        if (exp_d) begin
          outstanding = 1'b1;
          waits = if_req ? ((waits < LIMIT) ? waits + 1 : LIMIT) : 0;
        end
        if (exp_i) begin
          outstanding = 1'b1;
          waits = 0;
        end
        if (dm_gnt) begin
          dm_gnt_total++;
          t_dm_gnt = $time;
        end
        if (if_gnt) begin
          dm_at_if_gnt = dm_gnt_total;
          t_if_gnt = $time;
        end
      end
    end
  end

  task automatic wait_gnt(input bit is_if, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (is_if ? if_gnt : dm_gnt) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL gnt_timeout: got no %s grant in 400 cycles, required a grant", is_if ? "if" : "dm");
    end
  endtask

  task automatic do_if(input logic [PW-1:0] a);
    bit   ok;
    txn_t t;
    if_req  = 1'b1;
    if_addr = a;
    wait_gnt(1'b1, ok);
    if (ok) begin
      exp_if_q.push_back(ref_rd(a[PW-1:2]));
      t.we = 1'b0; t.addr = 16'(a); t.wdata = 32'h0; t.wstrb = 4'h0; t.is_if = 1'b1;
      txn_q.push_back(t);
    end
    @(posedge clk); #1;
    if_req  = 1'b0;
    if_addr = PW'($urandom);
  endtask

  task automatic do_dm(input logic we, input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] ws);
    bit          ok;
    txn_t        t;
    dexp_t       de;
    logic [13:0] ix;
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; dm_wstrb = ws;
    wait_gnt(1'b0, ok);
    if (ok) begin
      ix = a[15:2];
      de.is_wr = we;
      de.data  = we ? 32'h0 : ref_rd(ix);
      if (we) ref_mem[ix] = merge(ref_rd(ix), wd, ws);
      exp_dm_q.push_back(de);
      t.we = we; t.addr = a; t.wdata = wd; t.wstrb = ws; t.is_if = 1'b0;
      txn_q.push_back(t);
    end
    @(posedge clk); #1;
    dm_req = 1'b0; dm_we = 1'($urandom); dm_addr = AW'($urandom);
    dm_wdata = $urandom; dm_wstrb = 4'($urandom);
  endtask

  task automatic do_dm_rand();
    int ix;
    ix = $urandom_range(0, 63);
    do_dm(1'($urandom_range(0, 1)), AW'(ix << 2), $urandom, 4'($urandom_range(0, 15)));
  endtask

  task automatic do_if_rand();
    int ix;
    ix = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 63) : $urandom_range(0, 1023);
    do_if(PW'(ix << 2));
  endtask

  task automatic wait_rv(input bit is_if, input int want_lat, input bit chk, input logic [31:0] want, input string nm);
    int c;
    c = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (is_if ? if_rvalid : dm_rvalid) begin
        c = k;
        break;
      end
    end
    total++;
    if (c != want_lat) begin
      bad++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", nm, c, want_lat);
    end
    if (chk) begin
      total++;
      if ((is_if ? if_rdata : dm_rdata) !== want) begin
        bad++;
        $display("FAIL %s_data: got %h, required %h", nm, is_if ? if_rdata : dm_rdata, want);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (exp_if_q.size() == 0 && exp_dm_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain_timeout: got %0d/%0d responses pending, required 0/0", exp_if_q.size(), exp_dm_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string nm);
    logic [2*MW+AW+MW+4+6:0] v;
    v = {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb};
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL %s_outputs: got gnt=%0b%0b rv=%0b%0b ifd=%h dmd=%h mreq=%0b we=%0b addr=%h wd=%h ws=%h, required all 0",
               nm, if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_rdata, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, rv0;
    reset_n = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #2; reset_n = 1'b1;
    @(posedge clk); #1;

    // Single fetch from 0x10, zero-wait memory
    ref_mem[14'h4]  = 32'h0050_0093;
    phys_mem[14'h4] = 32'h0050_0093;
    fixed_lat = 0;
    do_if(12'h010);
    wait_rv(1'b1, 2, 1'b1, 32'h0050_0093, "fetch");

    // Write then read back 0x40
    do_dm(1'b1, 16'h0040, 32'hDEAD_BEEF, 4'hF);
    wait_rv(1'b0, 2, 1'b0, 32'h0, "write");
    do_dm(1'b0, 16'h0040, 32'h0, 4'h0);
    wait_rv(1'b0, 2, 1'b1, 32'hDEAD_BEEF, "read");

    // Simultaneous requests with an empty starvation counter
    fork
      do_if(12'h020);
      do_dm(1'b0, 16'h0044, 32'h0, 4'h0);
    join
    drain();
    total++;
    if (!(t_dm_gnt < t_if_gnt && t_if_gnt == t_dm_rv)) begin
      bad++;
      $display("FAIL simul_order: got dm_gnt@%0t if_gnt@%0t dm_rv@%0t, required dm first and if_gnt at dm_rv",
               t_dm_gnt, t_if_gnt, t_dm_rv);
    end

    // Starvation bound, twice to show the counter restarts after the fetch
    for (int r = 0; r < 2; r++) begin
      c0 = dm_gnt_total;
      fork
        do_if(12'h100);
        begin
          for (int i = 0; i < 7; i++) do_dm_rand();
        end
      join
      drain();
      total++;
      if (dm_at_if_gnt - c0 != LIMIT) begin
        bad++;
        $display("FAIL starve_bound: got %0d dm grants before if_gnt, required %0d", dm_at_if_gnt - c0, LIMIT);
      end
    end

    // Five-cycle memory latency
    fixed_lat = 4;
    do_dm(1'b0, 16'h0040, 32'h0, 4'h0);
    wait_rv(1'b0, 6, 1'b1, 32'hDEAD_BEEF, "wait_states");

    // Reset while a DM read is outstanding
    fixed_lat = 8;
    do_dm(1'b0, 16'h0080, 32'h0, 4'h0);
    @(posedge clk); #2; reset_n = 1'b0;
    @(posedge clk); #2; reset_n = 1'b1;
    @(negedge clk);
    check_zero("reset_busy");
    rv0 = dm_rv_total;
    repeat (12) @(negedge clk);
    total++;
    if (dm_rv_total != rv0) begin
      bad++;
      $display("FAIL abandoned_rvalid: got %0d dm_rvalid pulses, required 0", dm_rv_total - rv0);
    end
    @(posedge clk); #1;
    fixed_lat = 0;
    do_dm(1'b0, 16'h0084, 32'h0, 4'h0);
    drain();

    // Randomized concurrent traffic with random wait states and stray mem_ready
    fixed_lat = -1;
    spurious_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_if_rand();
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_dm_rand();
        end
      end
    join
    drain();
    spurious_en = 1'b0;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
